fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator_if.sv | 30 +++
 rtl/fir_decimator.sv | 101 ++++++++++
 tb/tb_fir_decimator.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decimator_if.sv
// ---------------------------------------------------------------------------
// fir_decimator_if : sample-in / decimated-sample-out bundle for fir_decimator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fir_decimator_if #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 8
);
  logic [NB_DATA-1:0]          i_data;
  logic                        i_valid;
  logic                        i_ready;
  logic [NB_DATA-1:0]          o_data;
  logic                        o_valid;
  logic [$clog2(FIFO_DEPTH):0] o_count;
  logic                        o_overflow;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid, o_count, o_overflow
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid, o_count, o_overflow
  );
endinterface

`default_nettype wire

// File: rtl/fir_decimator.sv
// ---------------------------------------------------------------------------
// fir_decimator : accumulate-and-dump decimator feeding a FWFT output FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_decimator #(
  parameter int NB_DATA    = 8,
  parameter int DEC_FACTOR = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst_n,
  fir_decimator_if.slave bus
);

  localparam int c_SHIFT = $clog2(DEC_FACTOR);
  localparam int c_ACC_W = NB_DATA + c_SHIFT;
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_SHIFT-1:0] c_LAST_PHASE = c_SHIFT'(DEC_FACTOR - 1);
  localparam logic [c_CNT_W-1:0] c_FULL       = c_CNT_W'(FIFO_DEPTH);

  logic [c_ACC_W-1:0] r_acc;
  logic [c_SHIFT-1:0] r_phase;
  logic [NB_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;

  logic [c_ACC_W-1:0] w_sum;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_write;

  // Accumulator is wide enough for DEC_FACTOR full-scale samples, so the
  // group sum cannot wrap and the average is simply its upper NB_DATA bits.
  always_comb begin
    w_sum   = r_acc + c_ACC_W'(bus.i_data);
    w_push  = bus.i_valid && (r_phase == c_LAST_PHASE);
    w_pop   = (r_count != '0) && bus.i_ready;
    w_full  = (r_count == c_FULL);
    w_write = w_push && (!w_full || w_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (bus.i_valid) begin
      if (w_push) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + c_SHIFT'(1);
      end
    end
  end

  // Storage needs no reset: o_data is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_sum[c_ACC_W-1:c_SHIFT];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_write && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.o_data     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.o_valid    = (r_count != '0);
  assign bus.o_count    = r_count;
  assign bus.o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fir_decimator.sv
// ---------------------------------------------------------------------------
// tb_fir_decimator : directed and randomized checks of fir_decimator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_decimator;

  localparam int NB_DATA    = 8;
  localparam int DEC_FACTOR = 4;
  localparam int FIFO_DEPTH = 8;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  fir_decimator_if #(.NB_DATA(NB_DATA), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  fir_decimator #(
    .NB_DATA   (NB_DATA),
    .DEC_FACTOR(DEC_FACTOR),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending group samples, expected FIFO contents, sticky flag
  int grp[$];
  int fifo_q[$];
  bit m_ovf;

  task automatic model_clear();
    grp.delete();
    fifo_q.delete();
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, return #1 after the edge
  task automatic cyc(input bit v, input int d, input bit r);
    bit pop;
    bit push;
    int sum;
    int avg;
    bus.i_valid = v;
    bus.i_data  = NB_DATA'(d);
    bus.i_ready = r;
    pop  = (fifo_q.size() > 0) && r;
    push = 1'b0;
    avg  = 0;
    if (v) begin
      grp.push_back(d);
      if (grp.size() == DEC_FACTOR) begin
        sum = 0;
        foreach (grp[i]) sum += grp[i];
        avg  = sum / DEC_FACTOR;
        push = 1'b1;
        grp.delete();
      end
    end
    if (pop) void'(fifo_q.pop_front());
    if (push) begin
      if (fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(avg);
      else m_ovf = 1'b1;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    i_rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_overflow !== 1'b0 || bus.o_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_idle: valid=%b count=%0d ovf=%b data=%0d, want 0/0/0/0",
               bus.o_valid, bus.o_count, bus.o_overflow, bus.o_data);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 9, 1'b0);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'd9) begin
      bad++;
      $display("FAIL reset_prefill: valid=%b data=%0d, want 1/9", bus.o_valid, bus.o_data);
    end
    i_rst_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_overflow !== 1'b0 || bus.o_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_async: valid=%b count=%0d ovf=%b data=%0d, want 0/0/0/0",
               bus.o_valid, bus.o_count, bus.o_overflow, bus.o_data);
    end
    do_reset();
  endtask

  task automatic test_basic();
    cyc(1'b1, 1, 1'b1);
    cyc(1'b1, 2, 1'b1);
    cyc(1'b1, 3, 1'b1);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early: valid=%b, want 0", bus.o_valid);
    end
    cyc(1'b1, 4, 1'b1);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'd2 || bus.o_count !== 4'd1) begin
      bad++;
      $display("FAIL basic_out: valid=%b data=%0d count=%0d, want 1/2/1",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    cyc(1'b0, 0, 1'b1);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
      bad++;
      $display("FAIL basic_pop: valid=%b count=%0d, want 0/0", bus.o_valid, bus.o_count);
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 4; i++) cyc(1'b1, 255, 1'b1);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'd255) begin
      bad++;
      $display("FAIL max_value: valid=%b data=%0d, want 1/255", bus.o_valid, bus.o_data);
    end
    cyc(1'b0, 0, 1'b1);
  endtask

  task automatic test_gaps();
    cyc(1'b1, 4, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b1, 8, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b1, 12, 1'b1);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL gaps_early: valid=%b, want 0", bus.o_valid);
    end
    cyc(1'b1, 16, 1'b1);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'd10 || bus.o_count !== 4'd1) begin
      bad++;
      $display("FAIL gaps_out: valid=%b data=%0d count=%0d, want 1/10/1",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    cyc(1'b0, 0, 1'b1);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 9; k++)
      for (int j = 0; j < 4; j++) cyc(1'b1, k, 1'b0);
    total++;
    if (bus.o_count !== 4'd8 || bus.o_overflow !== 1'b1 || bus.o_data !== 8'd1) begin
      bad++;
      $display("FAIL ovf_full: count=%0d ovf=%b data=%0d, want 8/1/1",
               bus.o_count, bus.o_overflow, bus.o_data);
    end
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(k)) begin
        bad++;
        $display("FAIL ovf_drain: valid=%b data=%0d, want 1/%0d", bus.o_valid, bus.o_data, k);
      end
      cyc(1'b0, 0, 1'b1);
    end
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: valid=%b ovf=%b, want 0/1", bus.o_valid, bus.o_overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 1; k <= 8; k++)
      for (int j = 0; j < 4; j++) cyc(1'b1, k, 1'b0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 9, 1'b0);
    cyc(1'b1, 9, 1'b1);
    total++;
    if (bus.o_count !== 4'd8 || bus.o_overflow !== 1'b0 || bus.o_data !== 8'd2) begin
      bad++;
      $display("FAIL full_pop: count=%0d ovf=%b data=%0d, want 8/0/2",
               bus.o_count, bus.o_overflow, bus.o_data);
    end
    for (int k = 2; k <= 9; k++) begin
      total++;
      if (bus.o_data !== 8'(k)) begin
        bad++;
        $display("FAIL full_pop_drain: data=%0d, want %0d", bus.o_data, k);
      end
      cyc(1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, 7, 1'b1);
    cyc(1'b1, 7, 1'b1);
    i_rst_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 8'd0 || bus.o_count !== 4'd0) begin
      bad++;
      $display("FAIL midrst_hold: valid=%b data=%0d count=%0d, want 0/0/0",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    @(posedge i_clk);
    #4;
    i_rst_n = 1'b1;
    cyc(1'b1, 1, 1'b1);
    cyc(1'b1, 1, 1'b1);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_partial: valid=%b, want 0", bus.o_valid);
    end
    cyc(1'b1, 1, 1'b1);
    cyc(1'b1, 1, 1'b1);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'd1 || bus.o_count !== 4'd1) begin
      bad++;
      $display("FAIL midrst_out: valid=%b data=%0d count=%0d, want 1/1/1",
               bus.o_valid, bus.o_data, bus.o_count);
    end
    cyc(1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    bit v;
    bit r;
    int d;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 255);
      r = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(v, d, r);
      total++;
      if (bus.o_count !== 4'(fifo_q.size()) || bus.o_valid !== (fifo_q.size() > 0)) begin
        bad++;
        $display("FAIL rand_count: cycle %0d count=%0d valid=%b, want %0d", n,
                 bus.o_count, bus.o_valid, fifo_q.size());
      end
      total++;
      if (bus.o_overflow !== m_ovf) begin
        bad++;
        $display("FAIL rand_ovf: cycle %0d ovf=%b, want %b", n, bus.o_overflow, m_ovf);
      end
      if (fifo_q.size() > 0) begin
        total++;
        if (bus.o_data !== 8'(fifo_q[0])) begin
          bad++;
          $display("FAIL rand_data: cycle %0d data=%0d, want %0d", n, bus.o_data, fifo_q[0]);
        end
      end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_max();
    test_gaps();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
